walksat_flip_scheduler: RTL and testbench

- Top-level flip sequencer for the WalkSAT core.
- Each step pops one unsatisfied-clause ID and fetches that clause's literals and their break values. It then drives the heuristic selector, issues the chosen variable flip to the update engine and waits for the update to complete.
- Counts flips against a limit and reports SAT or timeout.

---
 rtl/walksat_flip_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_walksat_flip_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/walksat_flip_scheduler.sv
// WalkSAT flip sequencer: pops unsat clauses, fetches literals/breaks, drives the selector, issues flips.
// Optional TABU_EN: the last flipped variable is masked out of the next selection unless that empties the mask.
module walksat_flip_scheduler #(
   parameter int unsigned NSAT                          = 3,
   parameter int unsigned NSAT_BITS                     = 2,
   parameter int unsigned MAX_CLAUSES_PER_VARIABLE_BITS = 5,
   parameter int unsigned VAR_BITS                      = 12,
   parameter int unsigned CLAUSE_BITS                   = 14,
   parameter int unsigned FLIP_CNT_BITS                 = 32,
   parameter int unsigned SEL_LATENCY                   = 2
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start_i,
   input  logic [FLIP_CNT_BITS-1:0]                      max_flips_i,
   input  logic                                          unsat_valid_i,
   input  logic [CLAUSE_BITS-1:0]                        unsat_clause_i,
   output logic                                          unsat_pop_o,
   output logic                                          lit_req_o,
   output logic [CLAUSE_BITS-1:0]                        lit_addr_o,
   input  logic                                          lit_ack_i,
   input  logic [NSAT*VAR_BITS-1:0]                      lit_vars_i,
   input  logic [NSAT-1:0]                               lit_mask_i,
   output logic                                          brk_req_o,
   output logic [NSAT*VAR_BITS-1:0]                      brk_vars_o,
   input  logic                                          brk_ack_i,
   input  logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] brk_values_i,
   output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] sel_break_values_o,
   output logic [NSAT-1:0]                               sel_valid_mask_o,
   input  logic [NSAT_BITS-1:0]                          select_i,
   output logic                                          flip_valid_o,
   output logic [VAR_BITS-1:0]                           flip_var_o,
   input  logic                                          flip_ready_i,
   input  logic                                          update_done_i,
   output logic                                          busy_o,
   output logic                                          sat_o,
   output logic                                          timeout_o,
   output logic [FLIP_CNT_BITS-1:0]                      flip_count_o
);

   localparam int unsigned BRK_W     = NSAT * MAX_CLAUSES_PER_VARIABLE_BITS;
   localparam int unsigned SEL_CNT_W = (SEL_LATENCY > 1) ? $clog2(SEL_LATENCY) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_POP, S_LIT, S_BRK, S_SEL, S_FLIP, S_UPD, S_ERR_SKIP
   } state_e;

   state_e                            state_q, state_d;
   logic [FLIP_CNT_BITS-1:0]          limit_q, limit_d;
   logic [FLIP_CNT_BITS-1:0]          count_q, count_d;
   logic [CLAUSE_BITS-1:0]            clause_q, clause_d;
   logic [NSAT-1:0][VAR_BITS-1:0]     vars_q, vars_d;
   logic [NSAT-1:0]                   lit_mask_q, lit_mask_d;
   logic [BRK_W-1:0]                  sel_brk_q, sel_brk_d;
   logic [NSAT-1:0]                   sel_mask_q, sel_mask_d;
   logic [SEL_CNT_W-1:0]              sel_cnt_q, sel_cnt_d;
   logic [VAR_BITS-1:0]               flip_var_q, flip_var_d;
   logic                              sat_q, sat_d, timeout_q, timeout_d;
   logic                              pop_q, pop_d, lit_req_q, lit_req_d, brk_req_q, brk_req_d;
   logic                              flip_valid_q, flip_valid_d, busy_q, busy_d;
   logic [NSAT-1:0]                   brk_mask_c;
   logic                              sel_bad_c;

`ifdef TABU_EN
   logic [VAR_BITS-1:0] tabu_q;
   logic                tabu_vld_q;
   logic [NSAT-1:0]     keep_c;

   // Last accepted flip becomes the tabu variable for the next step.
   always_ff @(posedge clk) begin
      if (reset) begin
         tabu_q     <= '0;
         tabu_vld_q <= 1'b0;
      end else if (state_q == S_IDLE && start_i) begin
         tabu_q     <= '0;
         tabu_vld_q <= 1'b0;
      end else if (state_q == S_FLIP && flip_ready_i) begin
         tabu_q     <= flip_var_q;
         tabu_vld_q <= 1'b1;
      end
   end

   always_comb begin
      keep_c = '0;
      for (int unsigned k = 0; k < NSAT; k++) begin
         keep_c[k] = lit_mask_q[k] && !(tabu_vld_q && (vars_q[k] == tabu_q));
      end
      brk_mask_c = (keep_c == '0) ? lit_mask_q : keep_c;
   end
`else
   assign brk_mask_c = lit_mask_q;
`endif

   assign sel_bad_c = (select_i == '1) || (32'(select_i) >= NSAT) || !sel_mask_q[select_i];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         limit_q      <= '0;
         count_q      <= '0;
         clause_q     <= '0;
         vars_q       <= '0;
         lit_mask_q   <= '0;
         sel_brk_q    <= '0;
         sel_mask_q   <= '0;
         sel_cnt_q    <= '0;
         flip_var_q   <= '0;
         sat_q        <= 1'b0;
         timeout_q    <= 1'b0;
         pop_q        <= 1'b0;
         lit_req_q    <= 1'b0;
         brk_req_q    <= 1'b0;
         flip_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         limit_q      <= limit_d;
         count_q      <= count_d;
         clause_q     <= clause_d;
         vars_q       <= vars_d;
         lit_mask_q   <= lit_mask_d;
         sel_brk_q    <= sel_brk_d;
         sel_mask_q   <= sel_mask_d;
         sel_cnt_q    <= sel_cnt_d;
         flip_var_q   <= flip_var_d;
         sat_q        <= sat_d;
         timeout_q    <= timeout_d;
         pop_q        <= pop_d;
         lit_req_q    <= lit_req_d;
         brk_req_q    <= brk_req_d;
         flip_valid_q <= flip_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next state; handshake outputs are registered decodes of the next state.
   always_comb begin
      state_d    = state_q;
      limit_d    = limit_q;
      count_d    = count_q;
      clause_d   = clause_q;
      vars_d     = vars_q;
      lit_mask_d = lit_mask_q;
      sel_brk_d  = sel_brk_q;
      sel_mask_d = sel_mask_q;
      sel_cnt_d  = sel_cnt_q;
      flip_var_d = flip_var_q;
      sat_d      = sat_q;
      timeout_d  = timeout_q;
      pop_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               limit_d   = max_flips_i;
               count_d   = '0;
               sat_d     = 1'b0;
               timeout_d = 1'b0;
               state_d   = S_POP;
            end
         end
         S_POP: begin
            if (!unsat_valid_i) begin
               sat_d   = 1'b1;
               state_d = S_IDLE;
            end else if (count_q == limit_q) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               clause_d = unsat_clause_i;
               pop_d    = 1'b1;
               state_d  = S_LIT;
            end
         end
         S_LIT: begin
            if (lit_ack_i) begin
               vars_d     = lit_vars_i;
               lit_mask_d = lit_mask_i;
               state_d    = (lit_mask_i == '0) ? S_ERR_SKIP : S_BRK;
            end
         end
         S_BRK: begin
            if (brk_ack_i) begin
               sel_brk_d  = brk_values_i;
               sel_mask_d = brk_mask_c;
               sel_cnt_d  = '0;
               state_d    = S_SEL;
            end
         end
         S_SEL: begin
            if (sel_cnt_q == SEL_CNT_W'(SEL_LATENCY - 1)) begin
               if (sel_bad_c) begin
                  state_d = S_ERR_SKIP;
               end else begin
                  flip_var_d = vars_q[select_i];
                  state_d    = S_FLIP;
               end
            end else begin
               sel_cnt_d = sel_cnt_q + SEL_CNT_W'(1);
            end
         end
         S_FLIP: begin
            if (flip_ready_i) begin
               if (count_q != '1) count_d = count_q + FLIP_CNT_BITS'(1);
               state_d = S_UPD;
            end
         end
         S_UPD: begin
            if (update_done_i) state_d = S_POP;
         end
         S_ERR_SKIP: state_d = S_POP;
         default:    state_d = S_IDLE;
      endcase

      lit_req_d    = (state_d == S_LIT);
      brk_req_d    = (state_d == S_BRK);
      flip_valid_d = (state_d == S_FLIP);
      busy_d       = (state_d != S_IDLE);
   end

   assign unsat_pop_o        = pop_q;
   assign lit_req_o          = lit_req_q;
   assign lit_addr_o         = clause_q;
   assign brk_req_o          = brk_req_q;
   assign brk_vars_o         = vars_q;
   assign sel_break_values_o = sel_brk_q;
   assign sel_valid_mask_o   = sel_mask_q;
   assign flip_valid_o       = flip_valid_q;
   assign flip_var_o         = flip_var_q;
   assign busy_o             = busy_q;
   assign sat_o              = sat_q;
   assign timeout_o          = timeout_q;
   assign flip_count_o       = count_q;

endmodule

// File: tb/tb_walksat_flip_scheduler.sv
// Scoreboard bench for walksat_flip_scheduler: expected flips and run outcomes queued by stimulus, checked by a monitor.
module tb_walksat_flip_scheduler;

   localparam int unsigned NSAT = 3;
   localparam int unsigned NB   = 2;
   localparam int unsigned BW   = 5;
   localparam int unsigned VB   = 12;
   localparam int unsigned CB   = 14;
   localparam int unsigned FCB  = 32;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start_i;
   logic [FCB-1:0]       max_flips_i;
   logic                 unsat_valid_i;
   logic [CB-1:0]        unsat_clause_i;
   logic                 unsat_pop_o;
   logic                 lit_req_o;
   logic [CB-1:0]        lit_addr_o;
   logic                 lit_ack_i;
   logic [NSAT*VB-1:0]   lit_vars_i;
   logic [NSAT-1:0]      lit_mask_i;
   logic                 brk_req_o;
   logic [NSAT*VB-1:0]   brk_vars_o;
   logic                 brk_ack_i;
   logic [NSAT*BW-1:0]   brk_values_i;
   logic [NSAT*BW-1:0]   sel_break_values_o;
   logic [NSAT-1:0]      sel_valid_mask_o;
   logic [NB-1:0]        select_i;
   logic                 flip_valid_o;
   logic [VB-1:0]        flip_var_o;
   logic                 flip_ready_i;
   logic                 update_done_i;
   logic                 busy_o;
   logic                 sat_o;
   logic                 timeout_o;
   logic [FCB-1:0]       flip_count_o;

   walksat_flip_scheduler dut (
      .clk(clk), .reset(reset), .start_i(start_i), .max_flips_i(max_flips_i),
      .unsat_valid_i(unsat_valid_i), .unsat_clause_i(unsat_clause_i), .unsat_pop_o(unsat_pop_o),
      .lit_req_o(lit_req_o), .lit_addr_o(lit_addr_o), .lit_ack_i(lit_ack_i),
      .lit_vars_i(lit_vars_i), .lit_mask_i(lit_mask_i),
      .brk_req_o(brk_req_o), .brk_vars_o(brk_vars_o), .brk_ack_i(brk_ack_i), .brk_values_i(brk_values_i),
      .sel_break_values_o(sel_break_values_o), .sel_valid_mask_o(sel_valid_mask_o), .select_i(select_i),
      .flip_valid_o(flip_valid_o), .flip_var_o(flip_var_o), .flip_ready_i(flip_ready_i),
      .update_done_i(update_done_i), .busy_o(busy_o), .sat_o(sat_o), .timeout_o(timeout_o),
      .flip_count_o(flip_count_o)
   );

   always #5 clk = ~clk;

   logic [NSAT*VB-1:0] mvars [16];
   logic [NSAT-1:0]    mmask [16];
   logic [NSAT*BW-1:0] mbrk  [16];
   logic [NB-1:0]      msel  [16];

   logic [CB-1:0]       fifo[$];
   logic [VB+FCB-1:0]   exp_flip[$];
   logic [FCB+1:0]      exp_end[$];

   int n_checks = 0;
   int n_err    = 0;
   int lit_delay = 0, ready_delay = 0, pop_cnt = 0, valid_cycles = 0;
   bit lit_chk_en = 1'b0;
   logic [CB-1:0] exp_lit_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_flip(input int v, input int c);
      exp_flip.push_back({VB'(v), FCB'(c)});
   endtask

   task automatic push_end(input bit s, input bit t, input int c);
      exp_end.push_back({s, t, FCB'(c)});
   endtask

   // Environment: FIFO, literal/break memories with configurable latency, selector, update engine.
   initial begin : responder
      int lit_cnt, rdy_cnt;
      bit done_pend;
      logic [3:0] a;
      logic [CB-1:0] tmp;
      lit_cnt = 0; rdy_cnt = 0; done_pend = 1'b0;
      unsat_valid_i = 1'b0; unsat_clause_i = '0; lit_ack_i = 1'b0; lit_vars_i = '0; lit_mask_i = '0;
      brk_ack_i = 1'b0; brk_values_i = '0; select_i = '0; flip_ready_i = 1'b0; update_done_i = 1'b0;
      forever begin
         @(negedge clk);
         if (unsat_pop_o) begin
            if (fifo.size() > 0) tmp = fifo.pop_front();
            pop_cnt++;
         end
         unsat_valid_i  = (fifo.size() != 0);
         unsat_clause_i = (fifo.size() != 0) ? fifo[0] : '0;
         a            = lit_addr_o[3:0];
         lit_vars_i   = mvars[a];
         lit_mask_i   = mmask[a];
         brk_values_i = mbrk[a];
         select_i     = msel[a];
         if (reset) begin
            lit_cnt = 0; rdy_cnt = 0; done_pend = 1'b0;
            lit_ack_i = 1'b0; brk_ack_i = 1'b0; flip_ready_i = 1'b0; update_done_i = 1'b0;
         end else begin
            if (lit_req_o) begin
               if (lit_cnt >= lit_delay) begin lit_ack_i = 1'b1; lit_cnt = 0; end
               else begin lit_ack_i = 1'b0; lit_cnt++; end
            end else begin
               lit_ack_i = 1'b0;
            end
            brk_ack_i     = brk_req_o;
            update_done_i = done_pend;
            done_pend     = 1'b0;
            if (flip_valid_o) begin
               valid_cycles++;
               if (rdy_cnt >= ready_delay) begin flip_ready_i = 1'b1; rdy_cnt = 0; done_pend = 1'b1; end
               else begin flip_ready_i = 1'b0; rdy_cnt++; end
            end else begin
               flip_ready_i = 1'b0;
            end
         end
      end
   end

   // Monitor: checks every flip-valid cycle and every end of run against the queued expectations.
   initial begin : monitor
      bit prev_busy, prev_valid;
      logic [VB+FCB-1:0] f;
      logic [FCB+1:0]    e;
      prev_busy = 1'b0; prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_flip.delete();
            prev_busy = 1'b0; prev_valid = 1'b0;
         end else begin
            if (flip_valid_o) begin
               if (exp_flip.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL flip_unexpected: got flip of var %0d, expected no flip", flip_var_o);
               end else begin
                  f = exp_flip[0];
                  chk("flip_var", 64'(flip_var_o), 64'(f[VB+FCB-1:FCB]));
                  chk("flip_count_hold", 64'(flip_count_o), 64'(f[FCB-1:0]));
               end
            end
            if (prev_valid && !flip_valid_o && exp_flip.size() != 0) begin
               f = exp_flip.pop_front();
               chk("flip_count_inc", 64'(flip_count_o), 64'(f[FCB-1:0]) + 64'd1);
            end
            if (lit_chk_en && lit_req_o) chk("lit_addr_hold", 64'(lit_addr_o), 64'(exp_lit_addr));
            if (prev_busy && !busy_o) begin
               if (exp_end.size() == 0) begin
                  n_checks++; n_err++;
                  $display("FAIL run_end_unexpected: got sat=%0b timeout=%0b count=%0d, expected busy", sat_o, timeout_o, flip_count_o);
               end else begin
                  e = exp_end.pop_front();
                  chk("run_end {sat,timeout,count}", 64'({sat_o, timeout_o, flip_count_o}), 64'(e));
               end
            end
            prev_busy  = busy_o;
            prev_valid = flip_valid_o;
         end
      end
   end

   task automatic run_test(input int maxf);
      bit done;
      valid_cycles = 0;
      pop_cnt      = 0;
      repeat (2) @(negedge clk);
      max_flips_i = FCB'(maxf);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 500 && !done; i++) begin
         @(negedge clk);
         if (!busy_o) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_err++;
         $display("FAIL run_timeout: got busy_o=1 after 500 cycles, expected run end");
      end
      @(negedge clk);
      chk("exp_flip_drained", 64'(exp_flip.size()), 64'd0);
      chk("exp_end_drained", 64'(exp_end.size()), 64'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ctrl"}, 64'({unsat_pop_o, lit_req_o, brk_req_o, flip_valid_o, busy_o, sat_o, timeout_o}), 64'd0);
      chk({name, "_count"}, 64'(flip_count_o), 64'd0);
      chk({name, "_data"}, 64'(|{lit_addr_o, brk_vars_o, sel_break_values_o, sel_valid_mask_o, flip_var_o}), 64'd0);
   endtask

   initial begin : stim
      bit got;
      for (int i = 0; i < 16; i++) begin
         mvars[i] = '0; mmask[i] = '0; mbrk[i] = '0; msel[i] = '0;
      end
      mvars[5]  = {12'd11, 12'd9, 12'd7};  mmask[5]  = 3'b111; mbrk[5]  = {5'd2, 5'd0, 5'd3}; msel[5]  = 2'd1;
      mvars[6]  = {12'd22, 12'd21, 12'd20}; mmask[6] = 3'b111; mbrk[6]  = {5'd0, 5'd4, 5'd1}; msel[6]  = 2'd2;
      mvars[7]  = '0;                       mmask[7] = 3'b000; msel[7]  = 2'd0;
      mvars[8]  = {12'd3, 12'd2, 12'd1};    mmask[8] = 3'b111; msel[8]  = 2'd3;
      mvars[9]  = {12'd32, 12'd31, 12'd30}; mmask[9] = 3'b101; msel[9]  = 2'd1;
      mvars[10] = {12'd6, 12'd4, 12'd9};    mmask[10] = 3'b111; mbrk[10] = {5'd2, 5'd1, 5'd0}; msel[10] = 2'd1;
      mvars[11] = {12'd0, 12'd0, 12'd9};    mmask[11] = 3'b001; mbrk[11] = {5'd0, 5'd0, 5'd5}; msel[11] = 2'd0;

      reset = 1'b1; start_i = 1'b0; max_flips_i = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");

      // Single step then SAT.
      fifo.push_back(14'd5);
      push_flip(9, 0); push_end(1'b1, 1'b0, 1);
      run_test(10);
      chk("t1_sel_break_values", 64'(sel_break_values_o), 64'({5'd2, 5'd0, 5'd3}));
      chk("t1_sel_valid_mask", 64'(sel_valid_mask_o), 64'(3'b111));
      chk("t1_brk_vars", 64'(brk_vars_o), 64'({12'd11, 12'd9, 12'd7}));
      chk("t1_pops", 64'(pop_cnt), 64'd1);

      // Timeout after two flips with work still queued.
      fifo.delete();
      fifo.push_back(14'd5); fifo.push_back(14'd6); fifo.push_back(14'd5); fifo.push_back(14'd6);
      push_flip(9, 0); push_flip(22, 1); push_end(1'b0, 1'b1, 2);
      run_test(2);
      chk("t2_pops", 64'(pop_cnt), 64'd2);

      // Zero limit times out without popping.
      fifo.delete();
      fifo.push_back(14'd5);
      push_end(1'b0, 1'b1, 0);
      run_test(0);
      chk("t3_pops", 64'(pop_cnt), 64'd0);

      // Backpressure on literal ack and flip ready.
      fifo.delete();
      fifo.push_back(14'd6);
      lit_delay = 3; ready_delay = 5; lit_chk_en = 1'b1; exp_lit_addr = 14'd6;
      push_flip(22, 0); push_end(1'b1, 1'b0, 1);
      run_test(10);
      chk("t4_valid_cycles", 64'(valid_cycles), 64'd6);
      lit_delay = 0; ready_delay = 0; lit_chk_en = 1'b0;

      // Error skips: empty mask, no selection, masked-off selection.
      fifo.delete();
      fifo.push_back(14'd7); fifo.push_back(14'd8); fifo.push_back(14'd9); fifo.push_back(14'd5);
      push_flip(9, 0); push_end(1'b1, 1'b0, 1);
      run_test(10);
      chk("t5_pops", 64'(pop_cnt), 64'd4);

      // Reset while a flip is stalled.
      fifo.delete();
      fifo.push_back(14'd6);
      ready_delay = 100;
      push_flip(22, 0);
      repeat (2) @(negedge clk);
      max_flips_i = 32'd10;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (flip_valid_o) got = 1'b1;
      end
      if (!got) begin
         n_checks++; n_err++;
         $display("FAIL t6_flip_wait: got no flip_valid_o in 50 cycles, expected flip");
      end
      repeat (2) @(negedge clk);
      chk("t6_valid_before_reset", 64'(flip_valid_o), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("t6_mid_reset");
      @(negedge clk);
      reset = 1'b0;
      ready_delay = 0;
      fifo.delete();
      fifo.push_back(14'd5);
      push_flip(9, 0); push_end(1'b1, 1'b0, 1);
      run_test(10);

      // Tabu masking of the previously flipped variable.
      fifo.delete();
      fifo.push_back(14'd5); fifo.push_back(14'd10);
      push_flip(9, 0); push_flip(4, 1); push_end(1'b1, 1'b0, 2);
      run_test(10);
`ifdef TABU_EN
      chk("t7_tabu_mask", 64'(sel_valid_mask_o), 64'(3'b110));
`else
      chk("t7_mask", 64'(sel_valid_mask_o), 64'(3'b111));
`endif

      // Tabu must not empty the mask.
      fifo.delete();
      fifo.push_back(14'd5); fifo.push_back(14'd11);
      push_flip(9, 0); push_flip(9, 1); push_end(1'b1, 1'b0, 2);
      run_test(10);
      chk("t8_mask_kept", 64'(sel_valid_mask_o), 64'(3'b001));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no end of test by 500000, expected $finish");
      $fatal(1);
   end

endmodule
